// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, the code-to-matrix table and emulator states.
// Encoder and emulator both decode through KEY_MAP so the two ends cannot diverge.
package keypad_pkg;

    localparam logic [3:0] KEY_PLUS  = 4'hA;
    localparam logic [3:0] KEY_MINUS = 4'hB;
    localparam logic [3:0] KEY_MUL   = 4'hC;
    localparam logic [3:0] KEY_DIV   = 4'hD;
    localparam logic [3:0] KEY_CLEAR = 4'hE;
    localparam logic [3:0] KEY_DP    = 4'hF;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } key_pos_t;

    // Entry n is {row, col} of key code n in the physical matrix.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'hD, 4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8,
        4'h9, 4'hA, 4'h3, 4'h7, 4'hB, 4'hF, 4'hE, 4'hC
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_PRESS = 2'd2,
        ST_GAP   = 2'd3
    } kp_state_e;

    function automatic key_pos_t key_decode(logic [3:0] code);
        return key_pos_t'(KEY_MAP[code]);
    endfunction

    function automatic logic [3:0] key_encode(key_pos_t pos);
        logic [3:0] code;
        code = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (KEY_MAP[i] == pos) code = 4'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Host handshake plus keypad scan lines between the poller/host side and the emulator.
interface keypad_emulator_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic       busy;
    logic       done;
    logic       timeout;

    modport master (
        output key_code, key_valid, col_in,
        input  key_ready, row_out, busy, done, timeout
    );

    modport slave (
        input  key_code, key_valid, col_in,
        output key_ready, row_out, busy, done, timeout
    );
endinterface

// File: rtl/keypad_scan_monitor.sv
// Detects scan boundaries (rising col_in[0]) and counts cycles between them for the
// emulator's timeout; a boundary always beats a coincident timeout.
module keypad_scan_monitor #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic col0_i,
    input  logic clear_i,
    input  logic active_i,
    output logic boundary_o,
    output logic timeout_o
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic          col0_q;
    logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;

    assign boundary_o = col0_i & ~col0_q;
    assign timeout_o  = active_i & ~boundary_o & (cyc_cnt_q == LAST);

    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        if (clear_i || boundary_o) begin
            cyc_cnt_d = '0;
        end else if (active_i && cyc_cnt_q != LAST) begin
            cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            col0_q    <= 1'b0;
            cyc_cnt_q <= '0;
        end else begin
            col0_q    <= col0_i;
            cyc_cnt_q <= cyc_cnt_d;
        end
    end
endmodule

// File: rtl/keypad_emulator.sv
// Emulated 4x4 key matrix: closes the requested key's switch for HOLD_SCANS full
// column scans, then keeps all switches open for GAP_SCANS scans before the next key.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned HOLD_SCANS     = 4,
    parameter int unsigned GAP_SCANS      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input logic               clk,
    input logic               rst_n,
    keypad_emulator_if.slave  bus
);
    localparam logic [7:0] HOLD_LIM = 8'(HOLD_SCANS);
    localparam logic [7:0] GAP_LIM  = 8'(GAP_SCANS);

    kp_state_e  state_q, state_d;
    logic [7:0] scan_cnt_q, scan_cnt_d;
    key_pos_t   pos_q, pos_d;
    logic [7:0] scan_inc;
    logic       accept, boundary, tmo_fire, done;
    logic [3:0] row_out;

    assign accept   = bus.key_valid && (state_q == ST_IDLE);
    assign scan_inc = (scan_cnt_q == 8'hFF) ? 8'hFF : scan_cnt_q + 8'd1;

    keypad_scan_monitor #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_mon (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .col0_i    (bus.col_in[0]),
        .clear_i   (accept),
        .active_i  (state_q != ST_IDLE),
        .boundary_o(boundary),
        .timeout_o (tmo_fire)
    );

    always_comb begin
        state_d    = state_q;
        scan_cnt_d = scan_cnt_q;
        pos_d      = pos_q;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_ARM;
                    scan_cnt_d = '0;
                    pos_d      = key_decode(bus.key_code);
                end
            end
            ST_ARM: begin
                if (boundary) begin
                    state_d    = ST_PRESS;
                    scan_cnt_d = '0;
                end else if (tmo_fire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESS: begin
                if (boundary) begin
                    if (scan_inc == HOLD_LIM) begin
                        state_d    = ST_GAP;
                        scan_cnt_d = '0;
                    end else begin
                        scan_cnt_d = scan_inc;
                    end
                end else if (tmo_fire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (boundary) begin
                    if (scan_inc == GAP_LIM) begin
                        state_d    = ST_IDLE;
                        scan_cnt_d = '0;
                        done       = 1'b1;
                    end else begin
                        scan_cnt_d = scan_inc;
                    end
                end else if (tmo_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Switch model: the row follows its column with no latency; opened in the abort cycle.
    always_comb begin
        row_out = '0;
        if (state_q == ST_PRESS && !tmo_fire) begin
            row_out[pos_q.row] = bus.col_in[pos_q.col];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            scan_cnt_q <= '0;
            pos_q      <= '0;
        end else begin
            state_q    <= state_d;
            scan_cnt_q <= scan_cnt_d;
            pos_q      <= pos_d;
        end
    end

    assign bus.row_out   = row_out;
    assign bus.key_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done;
    assign bus.timeout   = tmo_fire;
endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: rotating column scan, table of all 16 keys,
// scoreboard of expected (row,col) per accepted key, and multi-cycle corner sequences.
module tb_keypad_emulator;

    typedef struct {
        logic [3:0] code;
        logic [1:0] row;
        logic [1:0] col;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_emulator_if bus();

    keypad_emulator #(
        .HOLD_SCANS    (4),
        .GAP_SCANS     (4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    vec_t       vecs [16];
    vec_t       sb_q [$];
    vec_t       pend;
    int         checks = 0, errors = 0;
    int         cyc = 0, ph = 0;
    bit         scan_on = 1'b0;
    logic [3:0] col_hold = 4'b0;
    logic       nxt_valid = 1'b0;
    logic [3:0] nxt_code = 4'h0;
    logic       prev_c0 = 1'b0;
    int         done_cnt = 0, tmo_cnt = 0, done_cyc = 0, tmo_cyc = 0, acc_cyc = 0;
    int         bnd_cyc = 0, bnd_since_acc = 0, press_cnt = 0, spurious = 0;
    bit         accepted = 1'b0, obs_valid = 1'b0;
    logic [1:0] obs_row = 2'd0, obs_col = 2'd0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic score();
        vec_t e;
        if (sb_q.size() == 0) begin
            chk("sb_nonempty_at_done", 32'(sb_q.size()), 1);
        end else begin
            e = sb_q.pop_front();
            chk($sformatf("pos_k%0h", e.code), {obs_valid, obs_row, obs_col}, {1'b1, e.row, e.col});
            chk($sformatf("press_cycles_k%0h", e.code), press_cnt, 32);
            chk($sformatf("spurious_k%0h", e.code), spurious, 0);
            chk($sformatf("done_boundary_k%0h", e.code), bnd_since_acc, 9);
        end
    endtask

    task automatic tick();
        logic [1:0] r, c;
        r = 2'd0;
        c = 2'd0;
        @(posedge clk);
        #1;
        bus.key_valid = nxt_valid;
        bus.key_code  = nxt_code;
        if (scan_on) begin
            bus.col_in = 4'(4'b0001 << (ph / 8));
            ph = (ph + 1) % 32;
        end else begin
            bus.col_in = col_hold;
        end
        @(negedge clk);
        cyc++;
        if (bus.col_in[0] && !prev_c0) begin
            bnd_cyc = cyc;
            bnd_since_acc++;
        end
        prev_c0 = bus.col_in[0];
        if (bus.row_out != 4'b0) begin
            press_cnt++;
            if ($countones(bus.row_out) != 1 || $countones(bus.col_in) != 1) begin
                spurious++;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.row_out[i]) r = i[1:0];
                    if (bus.col_in[i]) c = i[1:0];
                end
                if (!obs_valid) begin
                    obs_valid = 1'b1;
                    obs_row = r;
                    obs_col = c;
                end else if (obs_row != r || obs_col != c) begin
                    spurious++;
                end
            end
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            score();
        end
        if (bus.timeout) begin
            tmo_cnt++;
            tmo_cyc = cyc;
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        if (bus.key_valid && bus.key_ready) begin
            acc_cyc = cyc;
            accepted = 1'b1;
            sb_q.push_back(pend);
            press_cnt = 0;
            spurious = 0;
            obs_valid = 1'b0;
            bnd_since_acc = 0;
        end
    endtask

    task automatic send(logic [3:0] code, logic [1:0] row, logic [1:0] col, bit keep);
        int n;
        nxt_valid = 1'b1;
        nxt_code  = code;
        pend      = '{code, row, col};
        accepted  = 1'b0;
        n = 0;
        while (!accepted && n < 700) begin
            tick();
            n++;
        end
        chk("accept_wait", accepted, 1);
        if (!keep) begin
            nxt_valid = 1'b0;
            nxt_code  = 4'($urandom);
        end
    endtask

    task automatic wait_done();
        int d0, n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < 600) begin
            tick();
            n++;
        end
        chk("done_wait", done_cnt - d0, 1);
    endtask

    int d0, t0, d1, b4, n;

    initial begin
        vecs[0]  = '{4'h1, 2'd0, 2'd0}; vecs[1]  = '{4'h2, 2'd0, 2'd1};
        vecs[2]  = '{4'h3, 2'd0, 2'd2}; vecs[3]  = '{4'hA, 2'd0, 2'd3};
        vecs[4]  = '{4'h4, 2'd1, 2'd0}; vecs[5]  = '{4'h5, 2'd1, 2'd1};
        vecs[6]  = '{4'h6, 2'd1, 2'd2}; vecs[7]  = '{4'hB, 2'd1, 2'd3};
        vecs[8]  = '{4'h7, 2'd2, 2'd0}; vecs[9]  = '{4'h8, 2'd2, 2'd1};
        vecs[10] = '{4'h9, 2'd2, 2'd2}; vecs[11] = '{4'hC, 2'd2, 2'd3};
        vecs[12] = '{4'hF, 2'd3, 2'd0}; vecs[13] = '{4'h0, 2'd3, 2'd1};
        vecs[14] = '{4'hE, 2'd3, 2'd2}; vecs[15] = '{4'hD, 2'd3, 2'd3};

        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.col_in    = 4'b1111;
        repeat (3) @(negedge clk);
        chk("rst_row_out", bus.row_out, 4'b0);
        chk("rst_key_ready", bus.key_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_timeout", bus.timeout, 0);
        rst_n = 1'b1;
        prev_c0 = bus.col_in[0];
        scan_on = 1'b1;
        ph = 0;

        // Key 5 under rotating scan.
        send(4'h5, 2'd1, 2'd1, 1'b0);
        d0 = done_cnt;
        wait_done();
        chk("k5_done_on_boundary", done_cyc, bnd_cyc);
        chk("k5_ready_in_done_cycle", bus.key_ready, 0);
        tick();
        chk("k5_ready_after_done", bus.key_ready, 1);
        chk("k5_done_single", bus.done, 0);
        repeat (40) tick();
        chk("k5_done_count", done_cnt - d0, 1);

        // All 16 codes from the layout table.
        for (int i = 0; i < 16; i++) begin
            send(vecs[i].code, vecs[i].row, vecs[i].col, 1'b0);
            wait_done();
        end

        // key_valid held: codes 1 then 2 back to back.
        send(4'h1, 2'd0, 2'd0, 1'b1);
        nxt_code = 4'h2;
        pend = '{4'h2, 2'd0, 2'd1};
        wait_done();
        d1 = done_cyc;
        accepted = 1'b0;
        n = 0;
        while (!accepted && n < 10) begin
            tick();
            n++;
        end
        chk("b2b_accept", accepted, 1);
        chk("b2b_gap_cycles", acc_cyc - d1, 1);
        nxt_valid = 1'b0;
        wait_done();

        // No scans at all: ARM times out.
        scan_on = 1'b0;
        col_hold = 4'b0000;
        d0 = done_cnt;
        t0 = tmo_cnt;
        send(4'h7, 2'd2, 2'd0, 1'b0);
        n = 0;
        while (tmo_cnt == t0 && n < 300) begin
            tick();
            n++;
        end
        chk("tmo_fired", tmo_cnt - t0, 1);
        chk("tmo_latency", tmo_cyc - acc_cyc, 100);
        chk("tmo_row_out", bus.row_out, 4'b0);
        tick();
        chk("tmo_no_done", done_cnt - d0, 0);
        chk("tmo_idle_ready", bus.key_ready, 1);
        chk("tmo_idle_busy", bus.busy, 0);
        chk("tmo_single", bus.timeout, 0);

        // Column 0 stuck high during GAP: no boundary, timeout instead of done.
        scan_on = 1'b1;
        ph = 0;
        d0 = done_cnt;
        t0 = tmo_cnt;
        send(4'h3, 2'd0, 2'd2, 1'b0);
        n = 0;
        while (press_cnt < 32 && n < 400) begin
            tick();
            n++;
        end
        chk("gap_press_done", press_cnt, 32);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.col_in != 4'b0001 && n < 40);
        b4 = cyc;
        chk("gap_b4_boundary", bnd_cyc, b4);
        scan_on = 1'b0;
        col_hold = 4'b0001;
        n = 0;
        while (tmo_cnt == t0 && n < 300) begin
            tick();
            n++;
        end
        chk("gap_tmo_fired", tmo_cnt - t0, 1);
        chk("gap_tmo_latency", tmo_cyc - b4, 100);
        chk("gap_no_done", done_cnt - d0, 0);
        chk("gap_press_total", press_cnt, 32);

        // Reset while key 9 is pressed.
        scan_on = 1'b1;
        ph = 16;
        send(4'h9, 2'd2, 2'd2, 1'b0);
        n = 0;
        while (bus.row_out == 4'b0 && n < 300) begin
            tick();
            n++;
        end
        chk("mid_press_seen", bus.row_out, 4'b0100);
        d0 = done_cnt;
        t0 = tmo_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_row_out", bus.row_out, 4'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        tick();
        chk("mid_rst_ready", bus.key_ready, 1);
        chk("mid_rst_busy", bus.busy, 0);
        repeat (400) tick();
        chk("mid_rst_no_done", done_cnt - d0, 0);
        chk("mid_rst_no_tmo", tmo_cnt - t0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
